// File: rtl/pueo_trig_merge.sv
// Merges soft/pps/ext trigger sources into one framed trigger stream with
// per-source pending queues, fixed priority, holdoff and event counting.
module pueo_trig_merge #(
    parameter int unsigned HOLDOFF_W  = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 sysclk_i,
    input  logic                 sysclk_rst_i,
    input  logic                 sysclk_phase_i,
    input  logic                 running_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic [11:0]          soft_trig_i,
    input  logic [11:0]          pps_trig_i,
    input  logic [11:0]          ext_trig_i,
    input  logic [7:0]           soft_metadata_i,
    input  logic [7:0]           pps_metadata_i,
    input  logic [7:0]           ext_metadata_i,
    input  logic                 soft_valid_i,
    input  logic                 pps_valid_i,
    input  logic                 ext_valid_i,
    output logic [11:0]          trig_o,
    output logic [7:0]           trig_metadata_o,
    output logic [1:0]           trig_src_o,
    output logic                 trig_valid_o,
    output logic [31:0]          event_count_o,
    output logic [2:0]           overflow_o
);

    localparam int unsigned NSRC = 3;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  meta;
    } entry_t;

    entry_t                  in_c [NSRC];
    entry_t                  head_c;
    entry_t                  mem [NSRC][FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr [NSRC];
    logic [AW-1:0]           rd_ptr [NSRC];
    logic [CW-1:0]           cnt [NSRC];
    logic [NSRC-1:0]         vld_c;
    logic [NSRC-1:0]         vld_q;
    logic [NSRC-1:0]         nonempty_c;
    logic [NSRC-1:0]         push_c;
    logic [NSRC-1:0]         accept_c;
    logic [NSRC-1:0]         pop_c;
    logic                    phase_q;
    logic [1:0]              pulse_left;
    logic [HOLDOFF_W-1:0]    holdoff_cnt;
    logic                    issue_c;
    logic [1:0]              sel_c;

    // Source bundling (index equals the trig_src_o encoding), capture and arbitration.
    always_comb begin
        in_c[0]    = '{addr: soft_trig_i, meta: soft_metadata_i};
        in_c[1]    = '{addr: pps_trig_i,  meta: pps_metadata_i};
        in_c[2]    = '{addr: ext_trig_i,  meta: ext_metadata_i};
        vld_c      = {ext_valid_i, pps_valid_i, soft_valid_i};
        nonempty_c = '0;
        push_c     = '0;
        pop_c      = '0;
        accept_c   = '0;
        head_c     = '0;
        sel_c      = 2'd0;

        for (int i = 0; i < NSRC; i++) begin
            nonempty_c[i] = (cnt[i] != '0);
            push_c[i]     = running_i && vld_c[i] && !vld_q[i];
        end

        // Frame k=1 is the cycle after the phase pulse; a running pulse blocks re-issue.
        issue_c = running_i && phase_q && (holdoff_cnt == '0) &&
                  (pulse_left == 2'd0) && (nonempty_c != '0);

        if (nonempty_c[1])      sel_c = 2'd1;
        else if (nonempty_c[2]) sel_c = 2'd2;
        else                    sel_c = 2'd0;

        for (int i = 0; i < NSRC; i++) begin
            pop_c[i]    = issue_c && (sel_c == 2'(i));
            accept_c[i] = push_c[i] && ((cnt[i] != CW'(FIFO_DEPTH)) || pop_c[i]);
            if (pop_c[i]) head_c = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            phase_q         <= 1'b0;
            vld_q           <= '0;
            pulse_left      <= 2'd0;
            holdoff_cnt     <= '0;
            event_count_o   <= '0;
            overflow_o      <= '0;
            trig_o          <= '0;
            trig_metadata_o <= '0;
            trig_src_o      <= '0;
            trig_valid_o    <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            phase_q <= sysclk_phase_i;
            vld_q   <= vld_c;

            // Four-cycle valid pulse, independent of running_i so it always completes.
            if (issue_c) begin
                trig_valid_o    <= 1'b1;
                pulse_left      <= 2'd3;
                trig_o          <= head_c.addr;
                trig_metadata_o <= head_c.meta;
                trig_src_o      <= sel_c;
            end else if (pulse_left != 2'd0) begin
                pulse_left <= pulse_left - 2'd1;
            end else begin
                trig_valid_o <= 1'b0;
            end

            if (!running_i) begin
                holdoff_cnt   <= '0;
                event_count_o <= '0;
                overflow_o    <= '0;
                for (int i = 0; i < NSRC; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    cnt[i]    <= '0;
                end
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (accept_c[i]) begin
                        mem[i][wr_ptr[i]] <= in_c[i];
                        wr_ptr[i]         <= wr_ptr[i] + AW'(1);
                    end
                    if (pop_c[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
                    cnt[i]        <= cnt[i] + CW'(accept_c[i]) - CW'(pop_c[i]);
                    overflow_o[i] <= overflow_o[i] | (push_c[i] & ~accept_c[i]);
                end

                if (issue_c) begin
                    holdoff_cnt   <= holdoff_i;
                    event_count_o <= event_count_o + 32'd1;
                end else if (phase_q && (holdoff_cnt != '0)) begin
                    holdoff_cnt <= holdoff_cnt - HOLDOFF_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pueo_trig_merge.sv
// Frame-level scoreboard bench for pueo_trig_merge: a queue model predicts each
// issued trigger, and a monitor compares every trig_valid_o pulse against it.
module tb_pueo_trig_merge;

    localparam int unsigned HW    = 16;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          phase;
    logic          running;
    logic [HW-1:0] hold_cfg;
    logic [11:0]   s_trig, p_trig, e_trig;
    logic [7:0]    s_meta, p_meta, e_meta;
    logic          s_vld, p_vld, e_vld;
    logic [11:0]   trig;
    logic [7:0]    trig_meta;
    logic [1:0]    trig_src;
    logic          trig_valid;
    logic [31:0]   event_count;
    logic [2:0]    overflow;

    always #5 clk = ~clk;

    pueo_trig_merge #(.HOLDOFF_W(HW), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk_i        (clk),
        .sysclk_rst_i    (rst),
        .sysclk_phase_i  (phase),
        .running_i       (running),
        .holdoff_i       (hold_cfg),
        .soft_trig_i     (s_trig),
        .pps_trig_i      (p_trig),
        .ext_trig_i      (e_trig),
        .soft_metadata_i (s_meta),
        .pps_metadata_i  (p_meta),
        .ext_metadata_i  (e_meta),
        .soft_valid_i    (s_vld),
        .pps_valid_i     (p_vld),
        .ext_valid_i     (e_vld),
        .trig_o          (trig),
        .trig_metadata_o (trig_meta),
        .trig_src_o      (trig_src),
        .trig_valid_o    (trig_valid),
        .event_count_o   (event_count),
        .overflow_o      (overflow)
    );

    typedef struct {
        logic [11:0] a;
        logic [7:0]  m;
        logic [1:0]  s;
        logic [31:0] n;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] mq0[$];
    logic [19:0] mq1[$];
    logic [19:0] mq2[$];
    int          checks = 0;
    int          errors = 0;
    int          m_hold = 0;
    logic [31:0] m_count = '0;
    logic [2:0]  m_ovf = '0;
    bit          abort_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        mq0.delete(); mq1.delete(); mq2.delete();
        m_hold  = 0;
        m_count = '0;
        m_ovf   = '0;
    endtask

    // Monitor: every rising trig_valid_o must match the oldest predicted issue.
    initial begin
        logic prev = 1'b0;
        int   len  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (trig_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got trig 0x%0h src %0d expected none at %0t",
                             trig, trig_src, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("trig_addr", 32'(trig), 32'(e.a));
                    check("trig_meta", 32'(trig_meta), 32'(e.m));
                    check("trig_src", 32'(trig_src), 32'(e.s));
                    check("issue_count", event_count, e.n);
                end
            end
            if (trig_valid) len++;
            else begin
                if (prev && !abort_pulse) check("pulse_len", 32'(len), 32'd4);
                len = 0;
            end
            prev = trig_valid;
        end
    end

    // One 8-clock frame; rst_c >= 0 asserts reset during that frame cycle.
    task automatic run_frame(input logic run, input logic [2:0] pulses, input int rst_c);
        logic [11:0] a [3];
        logic [7:0]  m [3];
        int          s;
        logic [19:0] ent;
        for (int i = 0; i < 3; i++) begin
            a[i] = 12'($urandom);
            m[i] = 8'($urandom);
        end
        running = run;
        if (!run) model_clear();
        else begin
            if (m_hold == 0 && (mq0.size() + mq1.size() + mq2.size()) > 0) begin
                if (mq1.size() > 0)      begin s = 1; ent = mq1.pop_front(); end
                else if (mq2.size() > 0) begin s = 2; ent = mq2.pop_front(); end
                else                     begin s = 0; ent = mq0.pop_front(); end
                m_count++;
                exp_q.push_back('{a: ent[19:8], m: ent[7:0], s: 2'(s), n: m_count});
                m_hold = int'(hold_cfg);
            end else if (m_hold > 0) m_hold--;
            if (pulses[0]) begin if (mq0.size() < DEPTH) mq0.push_back({a[0], m[0]}); else m_ovf[0] = 1'b1; end
            if (pulses[1]) begin if (mq1.size() < DEPTH) mq1.push_back({a[1], m[1]}); else m_ovf[1] = 1'b1; end
            if (pulses[2]) begin if (mq2.size() < DEPTH) mq2.push_back({a[2], m[2]}); else m_ovf[2] = 1'b1; end
        end
        s_trig = a[0]; s_meta = m[0];
        p_trig = a[1]; p_meta = m[1];
        e_trig = a[2]; e_meta = m[2];
        for (int c = 0; c < 8; c++) begin
            phase = (c == 0);
            s_vld = pulses[0] && c >= 2 && c <= 5;
            p_vld = pulses[1] && c >= 2 && c <= 5;
            e_vld = pulses[2] && c >= 2 && c <= 5;
            rst   = (c == rst_c);
            @(posedge clk);
            #1;
            if (c == rst_c) begin
                rst = 1'b0;
                check("rst_valid", 32'(trig_valid), 32'd0);
                check("rst_trig", 32'(trig), 32'd0);
                check("rst_meta", 32'(trig_meta), 32'd0);
                check("rst_src", 32'(trig_src), 32'd0);
                check("rst_count", event_count, 32'd0);
                check("rst_ovf", 32'(overflow), 32'd0);
                model_clear();
            end
        end
        check("event_count", event_count, m_count);
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        rst = 1'b1; phase = 1'b0; running = 1'b0; hold_cfg = '0;
        s_trig = '0; p_trig = '0; e_trig = '0;
        s_meta = '0; p_meta = '0; e_meta = '0;
        s_vld = 1'b0; p_vld = 1'b0; e_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", 32'(trig_valid), 32'd0);
        check("reset_trig", 32'(trig), 32'd0);
        check("reset_meta", 32'(trig_meta), 32'd0);
        check("reset_src", 32'(trig_src), 32'd0);
        check("reset_count", event_count, 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);

        // Single pps trigger, no holdoff.
        run_frame(1'b1, 3'b010, -1);
        repeat (2) run_frame(1'b1, 3'b000, -1);
        // All three sources together: pps, ext, soft on consecutive frames.
        run_frame(1'b1, 3'b111, -1);
        repeat (4) run_frame(1'b1, 3'b000, -1);
        // Holdoff 2 with ext every frame.
        run_frame(1'b0, 3'b000, -1);
        hold_cfg = 16'd2;
        repeat (10) run_frame(1'b1, 3'b100, -1);
        repeat (3) run_frame(1'b1, 3'b000, -1);
        // Holdoff 5 with back-to-back soft pulses to force a drop.
        run_frame(1'b0, 3'b000, -1);
        hold_cfg = 16'd5;
        repeat (4) run_frame(1'b1, 3'b001, -1);
        // Stop while entries are queued, then restart with idle inputs.
        run_frame(1'b0, 3'b000, -1);
        repeat (3) run_frame(1'b1, 3'b000, -1);
        // Reset in the middle of an issued pulse drops the queued ext entry.
        run_frame(1'b0, 3'b000, -1);
        hold_cfg = 16'd0;
        run_frame(1'b1, 3'b110, -1);
        abort_pulse = 1'b1;
        run_frame(1'b1, 3'b000, 3);
        abort_pulse = 1'b0;
        repeat (3) run_frame(1'b1, 3'b000, -1);

        // Randomized traffic with occasional stop/holdoff changes.
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 14) == 0) begin
                run_frame(1'b0, 3'($urandom), -1);
                hold_cfg = HW'($urandom_range(0, 3));
            end else begin
                run_frame(1'b1, 3'($urandom) & 3'($urandom), -1);
            end
        end
        repeat (2) run_frame(1'b1, 3'b000, -1);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
